// File: rtl/mon_prod_var_if.sv
// Request/response bundle for the Montgomery product engine.
// master drives start/A/B/M/num_words; slave returns busy/stop/err/P.
interface mon_prod_var_if #(
  parameter int BIT_LEN     = 64,
  parameter int COUNT_WIDTH = 5
);
  logic                   start;
  logic [BIT_LEN-1:0]     A;
  logic [BIT_LEN-1:0]     B;
  logic [BIT_LEN-1:0]     M;
  logic [COUNT_WIDTH-1:0] num_words;
  logic                   busy;
  logic                   stop;
  logic                   err;
  logic [BIT_LEN-1:0]     P;

  modport master (
    output start, A, B, M, num_words,
    input  busy, stop, err, P
  );

  modport slave (
    input  start, A, B, M, num_words,
    output busy, stop, err, P
  );
endinterface

// File: rtl/mon_prod_var.sv
// Bit-serial Montgomery product P = A*B*2^-n mod M, n = num_words*WORD_LEN.
// Ports: clk, rst (sync, active high), bus (slave side of mon_prod_var_if).
module mon_prod_var #(
  parameter int BIT_LEN     = 64,
  parameter int WORD_LEN    = 16,
  parameter int COUNT_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  mon_prod_var_if.slave  bus
);
  localparam int AW     = BIT_LEN + 2;
  localparam int NW_MAX = BIT_LEN / WORD_LEN;
  localparam int CW     = $clog2(BIT_LEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [BIT_LEN-1:0] a_q, a_d;
  logic [BIT_LEN-1:0] b_q, b_d;
  logic [BIT_LEN-1:0] m_q, m_d;
  logic [CW-1:0]      n_q, n_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [BIT_LEN-1:0] p_q, p_d;
  logic               err_q, err_d;
  logic               stop_q, stop_d;

  logic [AW-1:0] m_ext;
  logic [AW-1:0] acc_add;
  logic [AW-1:0] acc_odd;
  logic [AW-1:0] acc_nxt;
  logic          req_ok;

  assign m_ext   = {2'b00, m_q};
  // a_q shifts right each iteration, so bit 0 is always A[i]
  assign acc_add = acc_q + (a_q[0] ? {2'b00, b_q} : '0);
  assign acc_odd = acc_add + (acc_add[0] ? m_ext : '0);
  assign acc_nxt = acc_odd >> 1;

  assign req_ok = bus.M[0]
               && (bus.num_words != '0)
               && (32'(bus.num_words) <= NW_MAX);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    p_d     = p_q;
    err_d   = err_q;
    stop_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = bus.A;
          b_d   = bus.B;
          m_d   = bus.M;
          n_d   = CW'(32'(bus.num_words) * WORD_LEN);
          acc_d = '0;
          cnt_d = '0;
          if (req_ok) begin
            state_d = S_RUN;
          end else begin
            p_d     = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        acc_d = acc_nxt;
        a_d   = a_q >> 1;
        if (cnt_q == n_q - CW'(1)) begin
          state_d = S_SUB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SUB: begin
        if (acc_q >= m_ext) begin
          p_d = BIT_LEN'(acc_q - m_ext);
        end else begin
          p_d = acc_q[BIT_LEN-1:0];
        end
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        // stop is registered, so it shows in the IDLE cycle that follows
        stop_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      err_q   <= err_d;
      stop_q  <= stop_d;
    end
  end

  assign bus.busy = (state_q == S_RUN) || (state_q == S_SUB);
  assign bus.stop = stop_q;
  assign bus.err  = err_q;
  assign bus.P    = p_q;
endmodule

// File: tb/tb_mon_prod_var.sv
// Scoreboard bench for mon_prod_var.
// Stimulus pushes expected results; a negedge monitor pops on stop.
module tb_mon_prod_var;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  typedef struct {
    logic [63:0] p;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb[$];

  mon_prod_var_if #(.BIT_LEN(64), .COUNT_WIDTH(5)) bus ();

  mon_prod_var #(
    .BIT_LEN(64),
    .WORD_LEN(16),
    .COUNT_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.stop) begin
      if (sb.size() == 0) begin
        check("unexpected_stop", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("P", bus.P, e.p);
        check("err", 64'(bus.err), 64'(e.err));
        check("latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic scramble();
    bus.A = {$urandom, $urandom};
    bus.B = {$urandom, $urandom};
    bus.M = {$urandom, $urandom};
    bus.num_words = 5'($urandom);
  endtask

  task automatic issue(input logic [63:0] a, b, m,
                       input logic [4:0]  nw,
                       input logic [63:0] pe,
                       input logic        ee,
                       input int          lat);
    exp_t e;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.M = m;
    bus.num_words = nw;
    bus.start = 1'b1;
    e.p = pe;
    e.err = ee;
    e.at = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    check("busy_after_accept", 64'(bus.busy), 64'(!ee));
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout_pending", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int c;
    exp_t e;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.M = '0;
    bus.num_words = '0;
    repeat (3) @(negedge clk);
    check("rst_P", bus.P, 64'd0);
    check("rst_stop", 64'(bus.stop), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b0;

    issue(64'd216, 64'd123, 64'd311, 5'd1, 64'd46, 1'b0, 18);
    wait_idle(100);

    issue(64'd1, 64'd1, 64'd311, 5'd1, 64'd150, 1'b0, 18);
    repeat (4) @(negedge clk);
    bus.A = 64'd5;
    bus.B = 64'd7;
    bus.M = 64'd311;
    bus.num_words = 5'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(100);
    repeat (30) @(negedge clk);

    bus.A = 64'd216;
    bus.B = 64'd123;
    bus.M = 64'd311;
    bus.num_words = 5'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_P", bus.P, 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_stop", 64'(bus.stop), 64'd0);
    check("abort_err", 64'(bus.err), 64'd0);
    repeat (30) @(negedge clk);

    issue(64'd216, 64'd123, 64'd311, 5'd1, 64'd46, 1'b0, 18);
    wait_idle(100);

    issue(64'd216 | (64'd1 << 40), 64'd123, 64'd311, 5'd1,
          64'd46, 1'b0, 18);
    wait_idle(100);

    issue(64'd0, 64'd123, 64'd311, 5'd4, 64'd0, 1'b0, 66);
    wait_idle(200);

    issue(64'd1, 64'd1, 64'd311, 5'd2, 64'd108, 1'b0, 34);
    wait_idle(200);

    issue(64'd1, 64'd1, 64'd311, 5'd4, 64'd157, 1'b0, 66);
    wait_idle(200);

    issue(64'd216, 64'd123, 64'd310, 5'd1, 64'd0, 1'b1, 1);
    wait_idle(20);
    issue(64'd1, 64'd1, 64'd311, 5'd1, 64'd150, 1'b0, 18);
    wait_idle(100);
    issue(64'd216, 64'd123, 64'd311, 5'd0, 64'd0, 1'b1, 1);
    wait_idle(20);
    issue(64'd216, 64'd123, 64'd311, 5'd5, 64'd0, 1'b1, 1);
    wait_idle(20);

    @(negedge clk);
    bus.A = 64'd216;
    bus.B = 64'd123;
    bus.M = 64'd311;
    bus.num_words = 5'd1;
    bus.start = 1'b1;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      e.p = 64'd46;
      e.err = 1'b0;
      e.at = c + 1 + 18 + 19 * k;
      sb.push_back(e);
    end
    while (cyc < c + 42) @(negedge clk);
    bus.start = 1'b0;
    wait_idle(200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mon_prod_var.md
MON_PROD_VAR -- requirements
Module: mon_prod_var

Interface
REQ-001 Parameter BIT_LEN, 64, maximum operand width in bits.
REQ-002 Parameter WORD_LEN, 16, word granularity in bits; BIT_LEN SHALL be an integer multiple of WORD_LEN.
REQ-003 Parameter COUNT_WIDTH, 5, width of num_words.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 A, B  input  BIT_LEN  multiplicands; A < M and B < M required.
REQ-008 M  input  BIT_LEN  modulus; must be odd.
REQ-009 num_words  input  COUNT_WIDTH  active length in words; n = num_words*WORD_LEN bits.
REQ-010 busy  output  1  high from the cycle after acceptance until stop.
REQ-011 stop  output  1  one-cycle completion pulse.
REQ-012 err  output  1  valid with stop; high if the request was rejected.
REQ-013 P  output  BIT_LEN  result = A*B*2^-n mod M; held until the next accepted start.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, SUB and DONE.
REQ-015 IDLE: on start=1, latch A, B, M and n; clear accumulator (BIT_LEN+2 bits) and iteration counter; go to RUN.
REQ-016 Rejection: if start is accepted with M[0]=0, num_words=0, or num_words > BIT_LEN/WORD_LEN, go directly to DONE with P=0 and err=1.
REQ-017 RUN, iteration i (0..n-1), one per cycle: acc += A[i] ? B : 0; if acc odd, acc += M; acc >>= 1.
REQ-018 RUN SHALL exit to SUB after exactly n iterations; bits of A at index >= n SHALL be ignored.
REQ-019 SUB, one cycle: P <= (acc >= M) ? acc - M : acc[BIT_LEN-1:0]; err <= 0; go to DONE.
REQ-020 DONE SHALL assert stop for exactly one cycle, then return to IDLE.
REQ-021 Latency SHALL be n+2 cycles from the accepting edge to stop high; a rejected request SHALL give stop 1 cycle after acceptance.
REQ-022 busy SHALL be high in RUN and SUB and low in IDLE and DONE.
REQ-023 start in any state other than IDLE SHALL be ignored, with no effect on the current operation.
REQ-024 start held high in DONE SHALL be accepted on the following IDLE edge, with back-to-back operations separated by one IDLE cycle.
REQ-025 Input changes after acceptance SHALL NOT affect the operation in progress.
REQ-026 The accumulator SHALL stay below 2M throughout; no intermediate result SHALL overflow BIT_LEN+2 bits.
REQ-027 P SHALL always be < M for valid inputs.

Reset
REQ-028 While rst=1 at a rising edge: state = IDLE; P = 0; stop, busy and err = 0; accumulator and counter cleared.
REQ-029 rst SHALL override start and any in-flight operation; no stop SHALL be produced for an aborted operation.
REQ-030 The first start SHALL be accepted on the first edge with rst=0 and start=1.

Verification
REQ-031 WORD_LEN=16; A=216, B=123, M=311, num_words=1 -> stop 18 cycles after acceptance; P=46; err=0.
REQ-032 A=1, B=1, M=311, num_words=1 -> P=150 (2^-16 mod 311); a second start pulsed during RUN is ignored, and stop occurs exactly once.
REQ-033 A=0, B=123, M=311, num_words=4 -> stop after 66 cycles; P=0; err=0.
REQ-034 M=310, or num_words=0, or num_words=5 -> stop 1 cycle after acceptance; err=1; P=0; busy never high.
REQ-035 rst asserted for one cycle at RUN iteration 5 -> all outputs 0 the next cycle and no stop; a new start afterwards gives the REQ-031 result.
REQ-036 start held high continuously for REQ-031 inputs -> stop pulses every 19 cycles, P=46 each time.
